// File: rtl/instruction_memory_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instruction_memory_loader_pkg
// Description : Shared types and default sizes for the instruction loader.
// Revision    : 1.0 - initial release
// ============================================================================
package instruction_memory_loader_pkg;

    localparam int DEFAULT_DEPTH  = 256;
    localparam int DEFAULT_ADDR_W = 8;
    localparam int DEFAULT_DATA_W = 8;

    // Word fed to the core whenever it must not execute program memory
    localparam logic [DEFAULT_DATA_W-1:0] HOLD_INSTR = 8'h00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/instruction_memory_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : instruction_memory_loader_if
// Description : Load-stream and fetch signals between host/core and loader.
// Revision    : 1.0 - initial release
// ============================================================================
interface instruction_memory_loader_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              load_start;
    logic              load_valid;
    logic              load_last;
    logic [DATA_W-1:0] load_data;
    logic              load_ready;
    logic [ADDR_W-1:0] read_address;
    logic [DATA_W-1:0] instruction;
    logic              running;
    logic [ADDR_W:0]   program_len;

    modport master (
        output load_start, load_valid, load_last, load_data, read_address,
        input  load_ready, instruction, running, program_len
    );

    modport slave (
        input  load_start, load_valid, load_last, load_data, read_address,
        output load_ready, instruction, running, program_len
    );
endinterface
`default_nettype wire

// File: rtl/instruction_memory_loader_imem_array.sv
`default_nettype none
// ============================================================================
// Module      : imem_array
// Description : DEPTH x DATA_W storage, one synchronous write, one async read.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_array #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  wire logic              clock,
    input  wire logic              we,
    input  wire logic [ADDR_W-1:0] waddr,
    input  wire logic [DATA_W-1:0] wdata,
    input  wire logic [ADDR_W-1:0] raddr,
    output      logic [DATA_W-1:0] rdata
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Contents survive reset so a reload only overwrites what it streams
    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            r_mem[waddr[IDX_W-1:0]] <= wdata;
        end
    end

    assign rdata = r_mem[raddr[IDX_W-1:0]];
endmodule
`default_nettype wire

// File: rtl/instruction_memory_loader.sv
`default_nettype none
// ============================================================================
// Module      : instruction_memory_loader
// Description : Run-time program loader and zero-latency fetch port for the core.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_memory_loader
    import instruction_memory_loader_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  wire logic                    clock,
    input  wire logic                    clear,
    instruction_memory_loader_if.slave   bus
);
    localparam logic [ADDR_W:0]   C_DEPTH    = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] C_LAST_PTR = ADDR_W'(DEPTH - 1);

    loader_state_t     r_state;
    loader_state_t     w_next_state;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W:0]   r_count;
    logic              w_accept;
    logic              w_load_ready;
    logic              w_running;
    logic              w_in_range;
    logic [DATA_W-1:0] w_rdata;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_state  <= IDLE;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_state <= w_next_state;
            // load_start wins over a same-cycle byte in every state
            if (bus.load_start) begin
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else if (w_accept) begin
                if (r_wr_ptr != C_LAST_PTR) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (r_count != C_DEPTH)     r_count  <= r_count + 1'b1;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_load_ready = 1'b0;
        w_running    = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.load_start) w_next_state = LOAD;
            end
            LOAD: begin
                w_load_ready = 1'b1;
                if (bus.load_start) begin
                    w_next_state = LOAD;
                end else if (bus.load_valid) begin
                    w_accept = 1'b1;
                    if (bus.load_last || (r_wr_ptr == C_LAST_PTR)) w_next_state = RUN;
                end
            end
            RUN: begin
                w_running = 1'b1;
                if (bus.load_start) w_next_state = LOAD;
            end
            default: w_next_state = IDLE;
        endcase
    end

    imem_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_imem_array (
        .clock (clock),
        .we    (w_accept),
        .waddr (r_wr_ptr),
        .wdata (bus.load_data),
        .raddr (bus.read_address),
        .rdata (w_rdata)
    );

    assign w_in_range       = ({1'b0, bus.read_address} < C_DEPTH);
    assign bus.instruction  = (w_running && w_in_range) ? w_rdata : DATA_W'(HOLD_INSTR);
    assign bus.load_ready   = w_load_ready;
    assign bus.running      = w_running;
    assign bus.program_len  = r_count;
endmodule
`default_nettype wire

// File: tb/tb_instruction_memory_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_memory_loader
// Description : Directed self-checking bench: 256-deep and 4-deep instances.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_memory_loader;
    logic clock;
    logic clear;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [7:0] d;

    instruction_memory_loader_if #(.ADDR_W(8), .DATA_W(8)) bus  ();
    instruction_memory_loader_if #(.ADDR_W(8), .DATA_W(8)) bus4 ();

    instruction_memory_loader #(.DEPTH(256), .ADDR_W(8), .DATA_W(8)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus.slave)
    );

    instruction_memory_loader #(.DEPTH(4), .ADDR_W(8), .DATA_W(8)) dut4 (
        .clock (clock),
        .clear (clear),
        .bus   (bus4.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] q);
        bus.read_address = a;
        #1;
        q = bus.instruction;
    endtask

    task automatic rd4(input logic [7:0] a, output logic [7:0] q);
        bus4.read_address = a;
        #1;
        q = bus4.instruction;
    endtask

    task automatic send(input logic [7:0] data, input logic last);
        bus.load_valid = 1'b1;
        bus.load_data  = data;
        bus.load_last  = last;
        step();
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
    endtask

    task automatic start();
        bus.load_start = 1'b1;
        step();
        bus.load_start = 1'b0;
    endtask

    initial begin
        logic [7:0] prog [4];
        prog[0] = 8'h41; prog[1] = 8'h52; prog[2] = 8'hC3; prog[3] = 8'h14;

        clear = 1'b0;
        bus.load_start = 0; bus.load_valid = 0; bus.load_last = 0; bus.load_data = 0;
        bus.read_address = 8'h05;
        bus4.load_start = 0; bus4.load_valid = 0; bus4.load_last = 0; bus4.load_data = 0;
        bus4.read_address = 8'h00;
        #12;
        check("reset_instr",   {8'h0, bus.instruction}, 16'h00);
        check("reset_running", {15'h0, bus.running},    16'h0);
        check("reset_ready",   {15'h0, bus.load_ready}, 16'h0);
        check("reset_len",     {7'h0, bus.program_len}, 16'h0);
        @(negedge clock);
        clear = 1'b1;

        // Basic 4-byte program
        start();
        check("load_ready", {15'h0, bus.load_ready}, 16'h1);
        for (int i = 0; i < 4; i++) begin
            check("pre_run", {15'h0, bus.running}, 16'h0);
            send(prog[i], i == 3);
        end
        check("run_after_last", {15'h0, bus.running},    16'h1);
        check("run_ready_low",  {15'h0, bus.load_ready}, 16'h0);
        check("len4",           {7'h0, bus.program_len}, 16'h4);
        for (int i = 0; i < 4; i++) begin
            rd(8'(i), d);
            check("prog_word", {8'h0, d}, {8'h0, prog[i]});
        end

        // Valid stalls for one cycle in the middle of the stream
        start();
        send(8'h66, 1'b0);
        bus.load_data = 8'h77;
        step();
        send(8'h88, 1'b1);
        check("stall_len", {7'h0, bus.program_len}, 16'h2);
        rd(8'h00, d); check("stall_m0", {8'h0, d}, 16'h66);
        rd(8'h01, d); check("stall_m1", {8'h0, d}, 16'h88);
        rd(8'h02, d); check("stall_m2", {8'h0, d}, 16'hC3);

        // Valid while running is ignored
        send(8'hEE, 1'b0);
        check("run_ign_len", {7'h0, bus.program_len}, 16'h2);
        rd(8'h02, d); check("run_ign_m2", {8'h0, d}, 16'hC3);

        // Restart mid-load, with a byte offered on the restart cycle
        start();
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        bus.load_start = 1'b1;
        send(8'h99, 1'b0);
        bus.load_start = 1'b0;
        send(8'hAA, 1'b1);
        check("restart_len", {7'h0, bus.program_len}, 16'h1);
        check("restart_run", {15'h0, bus.running},    16'h1);
        rd(8'h00, d); check("restart_m0", {8'h0, d}, 16'hAA);
        rd(8'h01, d); check("restart_m1", {8'h0, d}, 16'h22);

        // Reload from RUN holds the core immediately
        start();
        rd(8'h00, d); check("reload_hold", {8'h0, d}, 16'h00);
        check("reload_running", {15'h0, bus.running}, 16'h0);

        // Asynchronous clear in the middle of a load
        send(8'h55, 1'b0);
        clear = 1'b0;
        #1;
        check("clr_running", {15'h0, bus.running},    16'h0);
        check("clr_ready",   {15'h0, bus.load_ready}, 16'h0);
        check("clr_len",     {7'h0, bus.program_len}, 16'h0);
        rd(8'h00, d); check("clr_instr", {8'h0, d}, 16'h00);
        clear = 1'b1;
        send(8'hBB, 1'b1);
        check("idle_ign_ready", {15'h0, bus.load_ready}, 16'h0);
        start();
        send(8'h5A, 1'b1);
        check("after_clr_len", {7'h0, bus.program_len}, 16'h1);
        rd(8'h00, d); check("after_clr_m0", {8'h0, d}, 16'h5A);
        rd(8'h01, d); check("after_clr_m1", {8'h0, d}, 16'h22);
        rd(8'h02, d); check("after_clr_m2", {8'h0, d}, 16'hC3);
        rd(8'h03, d); check("after_clr_m3", {8'h0, d}, 16'h14);

        // Memory-full termination on the 4-deep instance
        bus4.load_start = 1'b1;
        step();
        bus4.load_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("full_ready", {15'h0, bus4.load_ready}, (i < 4) ? 16'h1 : 16'h0);
            bus4.load_valid = 1'b1;
            bus4.load_data  = 8'hA0 + 8'(i);
            step();
        end
        bus4.load_valid = 1'b0;
        check("full_running", {15'h0, bus4.running},    16'h1);
        check("full_len",     {7'h0, bus4.program_len}, 16'h4);
        rd4(8'h00, d); check("full_m0", {8'h0, d}, 16'hA0);
        rd4(8'h03, d); check("full_m3", {8'h0, d}, 16'hA3);
        rd4(8'h04, d); check("full_oor", {8'h0, d}, 16'h00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
